pc_sequencer: RTL and testbench

- Parametrised successor to the core program counter. Generates fetch addresses.
- Supports stall, a registered redirect bubble, PC-relative branches with a signed offset, register-indirect jumps, link generation for JAL, an explicit return, and a halt state.
- Sits between the decode/control unit and instruction memory. It drives instruction-memory address and issue-valid signals, and drives link-register writeback to the register file.

---
 rtl/pc_pkg.sv | 67 ++++++
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/pc_ras.sv | 59 +++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// pc_pkg : condition codes, flag indices, sequencer states, branch predicate
// Rev 1.0
// ============================================================================
package pc_pkg;

  localparam logic [3:0] COND_EQ  = 4'd0;
  localparam logic [3:0] COND_NE  = 4'd1;
  localparam logic [3:0] COND_CS  = 4'd2;
  localparam logic [3:0] COND_CC  = 4'd3;
  localparam logic [3:0] COND_HI  = 4'd4;
  localparam logic [3:0] COND_LS  = 4'd5;
  localparam logic [3:0] COND_GT  = 4'd6;
  localparam logic [3:0] COND_LE  = 4'd7;
  localparam logic [3:0] COND_FS  = 4'd8;
  localparam logic [3:0] COND_FC  = 4'd9;
  localparam logic [3:0] COND_LO  = 4'd10;
  localparam logic [3:0] COND_HS  = 4'd11;
  localparam logic [3:0] COND_LT  = 4'd12;
  localparam logic [3:0] COND_GE  = 4'd13;
  localparam logic [3:0] COND_UC  = 4'd14;
  localparam logic [3:0] COND_JAL = 4'd15;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  function automatic logic cond_taken(input logic [3:0] cond, input logic [4:0] flags);
    logic c, l, f, z, n, taken;
    c = flags[FLAG_C];
    l = flags[FLAG_L];
    f = flags[FLAG_F];
    z = flags[FLAG_Z];
    n = flags[FLAG_N];
    case (cond)
      COND_EQ:  taken = z;
      COND_NE:  taken = ~z;
      COND_CS:  taken = c;
      COND_CC:  taken = ~c;
      COND_HI:  taken = l;
      COND_LS:  taken = ~l;
      COND_GT:  taken = n;
      COND_LE:  taken = ~n;
      COND_FS:  taken = f;
      COND_FC:  taken = ~f;
      COND_LO:  taken = ~l & ~z;
      COND_HS:  taken = l | z;
      COND_LT:  taken = ~n & ~z;
      COND_GE:  taken = n | z;
      COND_UC:  taken = 1'b1;
      COND_JAL: taken = 1'b1;
      default:  taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// pc_sequencer_if : control requests in, fetch address / link writeback out
// Rev 1.0
// ============================================================================
interface pc_sequencer_if #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 16
);
  logic                 stall;
  logic                 halt;
  logic [3:0]           cond;
  logic [4:0]           flags;
  logic [IMM_WIDTH-1:0] imm;
  logic [WIDTH-1:0]     r_target;
  logic                 pc_add;
  logic                 pc_branch;
  logic                 pc_jump;
  logic                 pc_ret;
  logic [WIDTH-1:0]     addr_out;
  logic                 issue_valid;
  logic [WIDTH-1:0]     link_out;
  logic                 link_we;
  logic                 ras_overflow;

  modport master (
    output stall, halt, cond, flags, imm, r_target,
           pc_add, pc_branch, pc_jump, pc_ret,
    input  addr_out, issue_valid, link_out, link_we, ras_overflow
  );

  modport slave (
    input  stall, halt, cond, flags, imm, r_target,
           pc_add, pc_branch, pc_jump, pc_ret,
    output addr_out, issue_valid, link_out, link_we, ras_overflow
  );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// pc_ras : circular return-address stack; full pushes overwrite the oldest
// Rev 1.0
// ============================================================================
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             overflow
);
  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL  = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   count;
  logic             overflow_r;

  // Storage is not reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count == FULL) begin
        overflow_r <= 1'b1;
      end else begin
        count <= count + (PTR_W + 1)'(1);
      end
    end else if (pop && (count != '0)) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - (PTR_W + 1)'(1);
    end
  end

  assign top_idx  = ptr - PTR_W'(1);
  assign top      = mem[top_idx];
  assign empty    = (count == '0);
  assign overflow = overflow_r;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : fetch-address sequencer with branch/jump/JAL/return and halt
// Optional return-address stack enabled by macro PC_RAS_EN.  Rev 1.0
// ============================================================================
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               IMM_WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  state_t           state, state_next;
  logic [WIDTH-1:0] pc, pc_next, pc_inc, offset, ret_addr;
  logic [WIDTH-1:0] link, link_next;
  logic             link_we_r, link_we_next;
  logic             run_go, taken;
  logic             sel_add, sel_branch, sel_jump, sel_ret;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
  end

  if (IMM_WIDTH < WIDTH) begin : g_imm_sext
    assign offset = {{(WIDTH - IMM_WIDTH){bus.imm[IMM_WIDTH-1]}}, bus.imm};
  end else begin : g_imm_trunc
    assign offset = bus.imm[WIDTH-1:0];
  end

  assign pc_inc     = pc + WIDTH'(1);
  assign taken      = cond_taken(bus.cond, bus.flags);
  assign run_go     = (state == ST_RUN) && !bus.stall && !bus.halt;
  assign sel_add    = run_go && bus.pc_add;
  assign sel_branch = run_go && !bus.pc_add && bus.pc_branch;
  assign sel_jump   = run_go && !bus.pc_add && !bus.pc_branch && bus.pc_jump;
  assign sel_ret    = run_go && !bus.pc_add && !bus.pc_branch && !bus.pc_jump && bus.pc_ret;

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty, ras_ovf, ras_push;

  assign ras_push = sel_jump && (bus.cond == COND_JAL);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (sel_ret),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_ovf)
  );

  assign ret_addr         = ras_empty ? bus.r_target : ras_top;
  assign bus.ras_overflow = ras_ovf;
`else
  assign ret_addr         = bus.r_target;
  assign bus.ras_overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= RESET_VECTOR;
      link      <= '0;
      link_we_r <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      link      <= link_next;
      link_we_r <= link_we_next;
    end
  end

  // A pending link write survives a stall and is released once it drops.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    link_next    = link;
    link_we_next = link_we_r;
    if (!bus.stall) begin
      link_we_next = 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.halt) begin
            state_next = ST_HALT;
          end else if (sel_add) begin
            pc_next = pc_inc;
          end else if (sel_branch) begin
            if (taken) begin
              pc_next    = pc + offset;
              state_next = ST_BUBBLE;
            end else begin
              pc_next = pc_inc;
            end
          end else if (sel_jump) begin
            if (taken) begin
              pc_next    = bus.r_target;
              state_next = ST_BUBBLE;
              if (bus.cond == COND_JAL) begin
                link_next    = pc_inc;
                link_we_next = 1'b1;
              end
            end else begin
              pc_next = pc_inc;
            end
          end else if (sel_ret) begin
            pc_next    = ret_addr;
            state_next = ST_BUBBLE;
          end
        end
        ST_BUBBLE: state_next = ST_RUN;
        ST_HALT:   state_next = ST_HALT;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  assign bus.addr_out    = pc;
  assign bus.issue_valid = (state == ST_RUN);
  assign bus.link_out    = link;
  assign bus.link_we     = link_we_r && !bus.stall;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed vector table, RAS sequence, randomized model check
// Rev 1.0
// ============================================================================
module tb_pc_sequencer;
  localparam int              W     = 16;
  localparam int              IW    = 16;
  localparam logic [W-1:0]    RV    = 16'h0000;
  localparam int              DEPTH = 4;

  typedef struct packed {
    logic        rst, stl, hlt, add, br, jmp, ret;
    logic [3:0]  cond;
    logic [4:0]  flags;
    logic [15:0] imm;
    logic [15:0] tgt;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_link;
    logic        e_lwe;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(W), .IMM_WIDTH(IW)) bus ();

  pc_sequencer #(
    .WIDTH        (W),
    .IMM_WIDTH    (IW),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: PC as a plain integer, mode 0=run 1=bubble 2=halt.
  int m_pc, m_mode, m_link;
  bit m_lwe, m_ovf;
  int m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit m_truth(input logic [3:0] c, input logic [4:0] f);
    bit fc, fl, ff, fz, fn, base;
    fc = f[0]; fl = f[1]; ff = f[2]; fz = f[3]; fn = f[4];
    case (int'(c) / 2)
      0: base = fz;
      1: base = fc;
      2: base = fl;
      3: base = fn;
      4: base = ff;
      5: base = !fl && !fz;
      6: base = !fn && !fz;
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model_step(input in_t i);
    int off;
    if (i.rst) begin
      m_pc = int'(RV); m_mode = 0; m_link = 0; m_lwe = 0; m_ovf = 0;
      m_ras.delete();
      return;
    end
    if (i.stl) return;
    m_lwe = 0;
    if (m_mode == 2) return;
    if (m_mode == 1) begin
      m_mode = 0;
      return;
    end
    if (i.hlt) begin
      m_mode = 2;
    end else if (i.add) begin
      m_pc = (m_pc + 1) % 65536;
    end else if (i.br) begin
      if (m_truth(i.cond, i.flags)) begin
        off    = int'($signed(i.imm));
        m_pc   = (m_pc + off + 65536) % 65536;
        m_mode = 1;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end else if (i.jmp) begin
      if (m_truth(i.cond, i.flags)) begin
        if (i.cond == 4'd15) begin
          m_link = (m_pc + 1) % 65536;
          m_lwe  = 1;
`ifdef PC_RAS_EN
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_ras.push_back(m_link);
`endif
        end
        m_pc   = int'(i.tgt);
        m_mode = 1;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end else if (i.ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else                  m_pc = int'(i.tgt);
      m_mode = 1;
    end
  endtask

  task automatic model_check(input in_t i);
    logic [15:0] epc, elink;
    epc   = m_pc[15:0];
    elink = m_link[15:0];
    check("model.addr_out",     bus.addr_out,     epc);
    check("model.issue_valid",  bus.issue_valid,  m_mode == 0);
    check("model.link_out",     bus.link_out,     elink);
    check("model.link_we",      bus.link_we,      m_lwe && !i.stl);
    check("model.ras_overflow", bus.ras_overflow, m_ovf);
  endtask

  task automatic apply(input in_t i);
    reset         = i.rst;
    bus.stall     = i.stl;
    bus.halt      = i.hlt;
    bus.pc_add    = i.add;
    bus.pc_branch = i.br;
    bus.pc_jump   = i.jmp;
    bus.pc_ret    = i.ret;
    bus.cond      = i.cond;
    bus.flags     = i.flags;
    bus.imm       = i.imm;
    bus.r_target  = i.tgt;
    @(posedge clk);
    model_step(i);
    #1;
    model_check(i);
  endtask

  function automatic in_t mk(input logic rst, stl, hlt, add, br, jmp, ret,
                             input logic [3:0] cond, input logic [4:0] flags,
                             input logic [15:0] imm, tgt);
    in_t r;
    r.rst = rst; r.stl = stl; r.hlt = hlt; r.add = add; r.br = br;
    r.jmp = jmp; r.ret = ret; r.cond = cond; r.flags = flags; r.imm = imm; r.tgt = tgt;
    return r;
  endfunction

  function automatic vec_t V(input in_t i, input logic [15:0] a, input logic v,
                             input logic [15:0] l, input logic lw);
    vec_t r;
    r.in = i; r.e_addr = a; r.e_valid = v; r.e_link = l; r.e_lwe = lw;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t RST, IDLE, ADD, STL, STLADD, HLT, HLTSTL, i;
    logic [15:0] exp_ret;

    RST    = mk(1,0,0,0,0,0,0, 4'd0, 5'd0, 16'h0, 16'h0);
    IDLE   = mk(0,0,0,0,0,0,0, 4'd0, 5'd0, 16'h0, 16'h0);
    ADD    = mk(0,0,0,1,0,0,0, 4'd0, 5'd0, 16'h0, 16'h0);
    STL    = mk(0,1,0,0,0,0,0, 4'd0, 5'd0, 16'h0, 16'h0);
    STLADD = mk(0,1,0,1,0,0,0, 4'd0, 5'd0, 16'h0, 16'h0);
    HLT    = mk(0,0,1,0,0,0,0, 4'd0, 5'd0, 16'h0, 16'h0);
    HLTSTL = mk(0,1,1,0,0,0,0, 4'd0, 5'd0, 16'h0, 16'h0);

    tbl.push_back(V(RST,  16'h0000, 1, 16'h0000, 0));
    tbl.push_back(V(ADD,  16'h0001, 1, 16'h0000, 0));
    tbl.push_back(V(ADD,  16'h0002, 1, 16'h0000, 0));
    tbl.push_back(V(ADD,  16'h0003, 1, 16'h0000, 0));
    tbl.push_back(V(ADD,  16'h0004, 1, 16'h0000, 0));
    tbl.push_back(V(RST,  16'h0000, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd14, 5'd0, 16'h0, 16'h0010), 16'h0010, 0, 16'h0000, 0));
    tbl.push_back(V(IDLE, 16'h0010, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,1,0,0, 4'd0, 5'b01000, 16'hFFFC, 16'h0), 16'h000C, 0, 16'h0000, 0));
    tbl.push_back(V(IDLE, 16'h000C, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd14, 5'd0, 16'h0, 16'h0010), 16'h0010, 0, 16'h0000, 0));
    tbl.push_back(V(IDLE, 16'h0010, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,1,0,0, 4'd0, 5'b00000, 16'hFFFC, 16'h0), 16'h0011, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd14, 5'd0, 16'h0, 16'h0020), 16'h0020, 0, 16'h0000, 0));
    tbl.push_back(V(IDLE, 16'h0020, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd15, 5'd0, 16'h0, 16'h0100), 16'h0100, 0, 16'h0021, 1));
    tbl.push_back(V(IDLE, 16'h0100, 1, 16'h0021, 0));
    tbl.push_back(V(mk(0,0,0,0,0,0,1, 4'd0, 5'd0, 16'h0, 16'h0021), 16'h0021, 0, 16'h0021, 0));
    tbl.push_back(V(IDLE, 16'h0021, 1, 16'h0021, 0));
    tbl.push_back(V(mk(0,0,0,0,1,0,0, 4'd14, 5'd0, 16'h0005, 16'h0), 16'h0026, 0, 16'h0021, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(V(STLADD, 16'h0026, 0, 16'h0021, 0));
    tbl.push_back(V(IDLE, 16'h0026, 1, 16'h0021, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(V(STLADD, 16'h0026, 1, 16'h0021, 0));
    tbl.push_back(V(ADD,  16'h0027, 1, 16'h0021, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd15, 5'd0, 16'h0, 16'h0200), 16'h0200, 0, 16'h0028, 1));
    tbl.push_back(V(STL,  16'h0200, 0, 16'h0028, 0));
    tbl.push_back(V(IDLE, 16'h0200, 1, 16'h0028, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd14, 5'd0, 16'h0, 16'hFFFF), 16'hFFFF, 0, 16'h0028, 0));
    tbl.push_back(V(IDLE, 16'hFFFF, 1, 16'h0028, 0));
    tbl.push_back(V(ADD,  16'h0000, 1, 16'h0028, 0));
    tbl.push_back(V(HLTSTL, 16'h0000, 1, 16'h0028, 0));
    tbl.push_back(V(HLT,  16'h0000, 0, 16'h0028, 0));
    tbl.push_back(V(ADD,  16'h0000, 0, 16'h0028, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd14, 5'd0, 16'h0, 16'h0055), 16'h0000, 0, 16'h0028, 0));
    tbl.push_back(V(RST,  16'h0000, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,1,0,0, 4'd14, 5'd0, 16'h0001, 16'h0), 16'h0001, 0, 16'h0000, 0));
    tbl.push_back(V(IDLE, 16'h0001, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,1,0,0, 4'd10, 5'd0, 16'h0010, 16'h0), 16'h0011, 0, 16'h0000, 0));
    tbl.push_back(V(IDLE, 16'h0011, 1, 16'h0000, 0));
    tbl.push_back(V(mk(0,0,0,0,0,1,0, 4'd13, 5'd0, 16'h0, 16'h0400), 16'h0012, 1, 16'h0000, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].in);
      check($sformatf("vec%0d.addr_out", k),    bus.addr_out,    tbl[k].e_addr);
      check($sformatf("vec%0d.issue_valid", k), bus.issue_valid, tbl[k].e_valid);
      check($sformatf("vec%0d.link_out", k),    bus.link_out,    tbl[k].e_link);
      check($sformatf("vec%0d.link_we", k),     bus.link_we,     tbl[k].e_lwe);
    end

    // Nested JALs then returns: with the stack, the oldest of five is overwritten.
    apply(RST);
    for (int k = 1; k <= 5; k++) begin
      apply(mk(0,0,0,0,0,1,0, 4'd15, 5'd0, 16'h0, 16'(k * 16'h1000)));
      check($sformatf("jal%0d.addr_out", k), bus.addr_out, 16'(k * 16'h1000));
      apply(IDLE);
    end
`ifdef PC_RAS_EN
    check("ras.overflow_set", bus.ras_overflow, 1'b1);
`else
    check("ras.overflow_tied", bus.ras_overflow, 1'b0);
`endif
    for (int k = 0; k < 5; k++) begin
`ifdef PC_RAS_EN
      exp_ret = (k < 4) ? 16'(16'h4001 - k * 16'h1000) : 16'hBEEF;
`else
      exp_ret = 16'hBEEF;
`endif
      apply(mk(0,0,0,0,0,0,1, 4'd0, 5'd0, 16'h0, 16'hBEEF));
      check($sformatf("ret%0d.addr_out", k), bus.addr_out, exp_ret);
      apply(IDLE);
    end

    apply(RST);
    for (int k = 0; k < 3000; k++) begin
      i.rst   = ($urandom_range(0, 39) == 0);
      i.stl   = ($urandom_range(0, 7) == 0);
      i.hlt   = ($urandom_range(0, 79) == 0);
      i.add   = ($urandom_range(0, 3) == 0);
      i.br    = $urandom_range(0, 1) == 1;
      i.jmp   = $urandom_range(0, 1) == 1;
      i.ret   = ($urandom_range(0, 2) == 0);
      i.cond  = 4'($urandom_range(0, 15));
      i.flags = 5'($urandom_range(0, 31));
      i.imm   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15) - 8)
                                            : 16'($urandom_range(0, 65535));
      i.tgt   = 16'($urandom_range(0, 65535));
      apply(i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
